button_event_decoder: RTL and testbench
=======================================

# button_event_decoder

Consumes the debounced, active-low push-button level from the board debouncer and converts it into single-cycle event pulses: press, release, short-click, double-click and long-hold. It sits directly downstream of the debouncer on the same system clock. Its outputs feed the FPGA core's register file and control logic, for example boot-mode and reset-request actions.

## Interface

Parameters:
- TICK_DIV, 25000: clk cycles per 1 ms timebase tick (25 MHz clk).
- LONG_MS, 1000: hold time, in ms, that qualifies a long press.
- DCLICK_MS, 300: maximum release-to-second-press gap, in ms, for a double-click.
- CNT_W, 12: width of the ms counter. Must satisfy 2^CNT_W > max(LONG_MS, DCLICK_MS).

Ports (clock and reset first):
- clk  in  1  system clock.
- reset_z  in  1  asynchronous, active-low reset.
- btn_z  in  1  debounced button level. Active-low (0 = pressed), idle high.
- enable  in  1  1 = decoding active. 0 = FSM held in IDLE and no event pulses.
- held  out  1  registered copy of ~btn_z.
- press_p  out  1  one-cycle pulse on each press edge.
- release_p  out  1  one-cycle pulse on each release edge.
- short_p  out  1  one-cycle pulse: single click qualified.
- double_p  out  1  one-cycle pulse: double click qualified.
- long_p  out  1  one-cycle pulse: hold reached LONG_MS.
- evt_cnt  out  8  count of short, double and long events. Wraps at 255 to 0.

## Operation

- Edge detection:
  - btn_d registers btn_z; reset value 1.
  - Press edge = btn_d & ~btn_z. Release edge = ~btn_d & btn_z.
- Timer:
  - A prescaler counts 0..TICK_DIV-1 and emits a tick on the wrap.
  - ms_cnt (CNT_W bits) increments on each tick and saturates at all-ones.
  - Both counters clear on every FSM state change.
- FSM states: IDLE, DOWN, LONG, GAP, DOWN2. Reset state is IDLE.
  - IDLE: press edge -> DOWN; pulse press_p.
  - DOWN:
    - ms_cnt reaches LONG_MS -> LONG; pulse long_p.
    - Release edge -> GAP; pulse release_p.
    - Both in the same cycle -> IDLE; long_p and release_p pulse together.
  - LONG: release edge -> IDLE; pulse release_p.
  - GAP:
    - Press edge -> DOWN2; pulse press_p and double_p.
    - ms_cnt reaches DCLICK_MS -> IDLE; pulse short_p.
    - Both in the same cycle -> the press wins, treated as a double-click; short_p is not issued.
  - DOWN2: release edge -> IDLE; pulse release_p. No long detection in this state.
- short_p, double_p and long_p are mutually exclusive in any cycle. evt_cnt increments on each of them.
- enable = 0:
  - State forced to IDLE; counters cleared; all *_p outputs held 0.
  - btn_d and held keep tracking the input.
  - Re-enabling while the button is already pressed produces no press_p; a fresh press edge is required.
- Reset values: state IDLE, btn_d 1, held 0, all *_p 0, evt_cnt 0, both counters 0.
- Reset asserted mid-operation clears everything immediately. A pending short or long decision is discarded with no pulse.

## Timing

- All outputs are registered.
- press_p and release_p are high in the cycle after btn_z is first sampled at its new level (1-cycle latency).
- held follows btn_z with 1-cycle latency.
- long_p asserts exactly LONG_MS*TICK_DIV cycles after the press_p of the same press.
- short_p asserts exactly DCLICK_MS*TICK_DIV cycles after release_p, provided no press edge arrives in between.
- evt_cnt shows its incremented value in the cycle after the event pulse.
- Every *_p output is high for exactly one cycle per event.

## Structure

- Shared constants go in params.v:
  - `button_tick_div, `button_long_ms, `button_dclick_ms.
  - FSM state encodings (3-bit localparams or `defines).
- One sub-module, ms_tick_timer:
  - Contains the prescaler plus the saturating ms counter.
  - Ports: clk, reset_z, clr, ms_cnt.
- Edge detect, FSM and evt_cnt stay in the top module.

## Test plan

All scenarios use TICK_DIV=4, LONG_MS=10, DCLICK_MS=5.

- Single click: btn_z low for 20 cycles, then high -> press_p, then release_p; short_p exactly 20 cycles after release_p; evt_cnt = 1.
- Long hold: btn_z low for 60 cycles -> long_p exactly 40 cycles after press_p; release gives release_p only; no short_p; evt_cnt = 1.
- Double click: press 8 cycles, release 8, press 8, release -> double_p in the same cycle as the second press_p; no short_p; evt_cnt = 1.
- Boundary collisions:
  - Release exactly at the long expiry cycle -> long_p and release_p in the same cycle; state returns to IDLE.
  - Second press exactly at the gap expiry cycle -> double_p and no short_p.
- enable = 0 during a held press, then re-enabled -> no pulses at all; the next fresh press gives a normal press_p.
- Reset mid-GAP, then release of reset -> all outputs 0 and evt_cnt = 0; no short_p ever appears.

Source files
------------

// File: rtl/button_event_decoder_pkg.sv
// Shared constants and types for the push-button event decoder.
//   BUTTON_*     : default timebase / threshold values (25 MHz clk, 1 ms tick)
//   btn_state_e  : decoder FSM state encoding (3 bits)
//   btn_evt_t    : one-hot-ish bundle of the five event pulses
//   is_scored()  : true for the events that advance evt_cnt
package button_event_decoder_pkg;

  localparam int BUTTON_TICK_DIV  = 25000;
  localparam int BUTTON_LONG_MS   = 1000;
  localparam int BUTTON_DCLICK_MS = 300;
  localparam int BUTTON_CNT_W     = 12;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_DOWN  = 3'd1,
    ST_LONG  = 3'd2,
    ST_GAP   = 3'd3,
    ST_DOWN2 = 3'd4
  } btn_state_e;

  typedef struct packed {
    logic press;
    logic rel;
    logic sclick;
    logic dclick;
    logic lhold;
  } btn_evt_t;

  function automatic logic is_scored(input btn_evt_t e);
    return e.sclick | e.dclick | e.lhold;
  endfunction

endpackage

// File: rtl/button_event_decoder_ms_tick_timer.sv
// Millisecond timebase: a prescaler wrapping every TICK_DIV clk cycles and a
// saturating ms counter advanced on each wrap. Both clear on clr.
//   clk, reset_z : clock, async active-low reset
//   clr          : synchronous clear of prescaler and ms counter
//   tick         : high in the cycle the prescaler wraps (ms_cnt advances at
//                  the following edge); lets the caller act on the edge where
//                  ms_cnt reaches a threshold rather than one cycle later
//   ms_cnt       : elapsed whole ms since the last clear, saturating
module ms_tick_timer
  import button_event_decoder_pkg::*;
#(
  parameter int TICK_DIV = BUTTON_TICK_DIV,
  parameter int CNT_W    = BUTTON_CNT_W
) (
  input  logic             clk,
  input  logic             reset_z,
  input  logic             clr,
  output logic             tick,
  output logic [CNT_W-1:0] ms_cnt
);

  localparam int            PW         = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

  logic [PW-1:0] presc;

  assign tick = (presc == PRESC_LAST);

  always_ff @(posedge clk or negedge reset_z) begin
    if (!reset_z) begin
      presc  <= '0;
      ms_cnt <= '0;
    end else if (clr) begin
      presc  <= '0;
      ms_cnt <= '0;
    end else if (tick) begin
      presc <= '0;
      if (ms_cnt != '1) ms_cnt <= ms_cnt + CNT_W'(1);
    end else begin
      presc <= presc + PW'(1);
    end
  end

endmodule

// File: rtl/button_event_decoder.sv
// Push-button event decoder: turns the debounced active-low button level into
// single-cycle press / release / short-click / double-click / long-hold pulses
// and counts the click/hold events.
//   clk, reset_z : clock, async active-low reset
//   btn_z        : debounced button level, 0 = pressed
//   enable       : 0 holds the FSM in IDLE and suppresses all pulses
//   held         : registered ~btn_z
//   press_p, release_p, short_p, double_p, long_p : registered 1-cycle pulses
//   evt_cnt      : wrapping count of short/double/long events
module button_event_decoder
  import button_event_decoder_pkg::*;
#(
  parameter int TICK_DIV  = BUTTON_TICK_DIV,
  parameter int LONG_MS   = BUTTON_LONG_MS,
  parameter int DCLICK_MS = BUTTON_DCLICK_MS,
  parameter int CNT_W     = BUTTON_CNT_W
) (
  input  logic       clk,
  input  logic       reset_z,
  input  logic       btn_z,
  input  logic       enable,
  output logic       held,
  output logic       press_p,
  output logic       release_p,
  output logic       short_p,
  output logic       double_p,
  output logic       long_p,
  output logic [7:0] evt_cnt
);

  localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_MS - 1);
  localparam logic [CNT_W-1:0] DCLICK_LAST = CNT_W'(DCLICK_MS - 1);

  logic             btn_d;
  logic             press_e, rel_e;
  btn_state_e       state, state_n;
  btn_evt_t         evt_n, evt_q;
  logic             tick, clr;
  logic [CNT_W-1:0] ms_cnt;
  logic             long_hit, gap_hit;

  // Edges are judged against the previous sample so the registered pulse
  // lands one cycle after btn_z is first seen at its new level.
  assign press_e = btn_d & ~btn_z;
  assign rel_e   = ~btn_d & btn_z;

  // "Reaches" means ms_cnt becomes the threshold at this edge, so the pulse
  // lands exactly threshold*TICK_DIV cycles after the entering edge.
  assign long_hit = tick & (ms_cnt == LONG_LAST);
  assign gap_hit  = tick & (ms_cnt == DCLICK_LAST);

  // Every state change restarts the timebase; disable keeps it parked at 0.
  assign clr = ~enable | (state_n != state);

  ms_tick_timer #(
    .TICK_DIV (TICK_DIV),
    .CNT_W    (CNT_W)
  ) u_timer (
    .clk     (clk),
    .reset_z (reset_z),
    .clr     (clr),
    .tick    (tick),
    .ms_cnt  (ms_cnt)
  );

  always_ff @(posedge clk or negedge reset_z) begin
    if (!reset_z) begin
      btn_d <= 1'b1;
      held  <= 1'b0;
    end else begin
      btn_d <= btn_z;
      held  <= ~btn_z;
    end
  end

  // FSM: state register
  always_ff @(posedge clk or negedge reset_z) begin
    if (!reset_z) state <= ST_IDLE;
    else          state <= state_n;
  end

  // FSM: next state
  always_comb begin
    state_n = state;
    if (!enable) begin
      state_n = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:  if (press_e) state_n = ST_DOWN;
        ST_DOWN: begin
          // release coinciding with expiry counts as a finished long hold
          if (rel_e)         state_n = long_hit ? ST_IDLE : ST_GAP;
          else if (long_hit) state_n = ST_LONG;
        end
        ST_LONG:  if (rel_e) state_n = ST_IDLE;
        ST_GAP: begin
          // a press on the expiry cycle still wins as a double-click
          if (press_e)      state_n = ST_DOWN2;
          else if (gap_hit) state_n = ST_IDLE;
        end
        ST_DOWN2: if (rel_e) state_n = ST_IDLE;
        default:  state_n = ST_IDLE;
      endcase
    end
  end

  // FSM: outputs (next-cycle pulse values)
  always_comb begin
    evt_n = '0;
    if (enable) begin
      case (state)
        ST_IDLE:  evt_n.press = press_e;
        ST_DOWN: begin
          evt_n.rel   = rel_e;
          evt_n.lhold = long_hit;
        end
        ST_LONG:  evt_n.rel = rel_e;
        ST_GAP: begin
          evt_n.press  = press_e;
          evt_n.dclick = press_e;
          evt_n.sclick = gap_hit & ~press_e;
        end
        ST_DOWN2: evt_n.rel = rel_e;
        default:  evt_n = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_z) begin
    if (!reset_z) begin
      evt_q   <= '0;
      evt_cnt <= '0;
    end else begin
      evt_q   <= evt_n;
      evt_cnt <= evt_cnt + {7'd0, is_scored(evt_q)};
    end
  end

  assign press_p   = evt_q.press;
  assign release_p = evt_q.rel;
  assign short_p   = evt_q.sclick;
  assign double_p  = evt_q.dclick;
  assign long_p    = evt_q.lhold;

endmodule

// File: tb/tb_button_event_decoder.sv
// Scoreboard bench for button_event_decoder (TICK_DIV=4, LONG_MS=10,
// DCLICK_MS=5). A timestamp-based reference model queues expected pulses as
// they become decidable; a negedge monitor pops and compares them.
module tb_button_event_decoder;

  localparam int TD = 4;
  localparam int LM = 10;
  localparam int DM = 5;
  localparam int CW = 8;

  localparam logic [4:0] E_PRESS  = 5'b10000;
  localparam logic [4:0] E_REL    = 5'b01000;
  localparam logic [4:0] E_SHORT  = 5'b00100;
  localparam logic [4:0] E_DOUBLE = 5'b00010;
  localparam logic [4:0] E_LONG   = 5'b00001;

  logic       clk;
  logic       reset_z;
  logic       btn_z;
  logic       enable;
  logic       held;
  logic       press_p, release_p, short_p, double_p, long_p;
  logic [7:0] evt_cnt;

  button_event_decoder #(
    .TICK_DIV (TD),
    .LONG_MS  (LM),
    .DCLICK_MS(DM),
    .CNT_W    (CW)
  ) dut (
    .clk      (clk),
    .reset_z  (reset_z),
    .btn_z    (btn_z),
    .enable   (enable),
    .held     (held),
    .press_p  (press_p),
    .release_p(release_p),
    .short_p  (short_p),
    .double_p (double_p),
    .long_p   (long_p),
    .evt_cnt  (evt_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input int act, input int want);
    checks++;
    if (act != want) begin
      failures++;
      if (failures <= 30)
        $display("FAIL %s at cycle-time %0t: got %0d expected %0d", name, $time, act, want);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    int         cyc;
    logic [4:0] vec;
    logic [7:0] cnt;
  } exp_t;

  exp_t q[$];

  // phases of a click gesture, tracked with timestamps of the last press/release
  localparam int M_IDLE = 0, M_FIRST = 1, M_HELD = 2, M_GAP = 3, M_SECOND = 4;

  int         cyc    = 0;
  int         m_mode = M_IDLE;
  int         t_mark = 0;
  bit         m_prev = 1'b0;
  bit         m_held = 1'b0;
  logic [7:0] m_cnt  = 8'd0;
  bit         b, pe, re, due;
  logic [4:0] v;

  always @(posedge clk or negedge reset_z) begin
    cyc++;
    if (!reset_z) begin
      m_prev = 1'b0;
      m_held = 1'b0;
      m_mode = M_IDLE;
      m_cnt  = 8'd0;
      q.delete();
    end else begin
      b      = !btn_z;
      pe     = b && !m_prev;
      re     = !b && m_prev;
      m_prev = b;
      m_held = b;
      v      = 5'b0;
      if (!enable) begin
        m_mode = M_IDLE;
      end else begin
        case (m_mode)
          M_IDLE: if (pe) begin
            v = E_PRESS; t_mark = cyc; m_mode = M_FIRST;
          end
          M_FIRST: begin
            due = (cyc - t_mark) == LM * TD;
            if (due) v = v | E_LONG;
            if (re) begin
              v = v | E_REL;
              m_mode = due ? M_IDLE : M_GAP;
              t_mark = cyc;
            end else if (due) begin
              m_mode = M_HELD;
            end
          end
          M_HELD, M_SECOND: if (re) begin
            v = E_REL; m_mode = M_IDLE;
          end
          M_GAP: begin
            if (pe) begin
              v = E_PRESS | E_DOUBLE; m_mode = M_SECOND;
            end else if ((cyc - t_mark) == DM * TD) begin
              v = E_SHORT; m_mode = M_IDLE;
            end
          end
          default: m_mode = M_IDLE;
        endcase
      end
      if (v != 5'b0) begin
        q.push_back('{cyc: cyc, vec: v, cnt: m_cnt});
        if ((v & (E_SHORT | E_DOUBLE | E_LONG)) != 5'b0) m_cnt = m_cnt + 8'd1;
      end
    end
  end

  // ---------------- monitor ----------------
  logic [4:0] dvec;
  exp_t       e;

  always @(negedge clk) begin
    dvec = {press_p, release_p, short_p, double_p, long_p};
    if (q.size() > 0 && q[0].cyc < cyc) begin
      e = q.pop_front();
      chk("missed_event", 0, int'(e.vec));
    end
    if (q.size() > 0 && q[0].cyc == cyc) begin
      e = q.pop_front();
      chk("event_pulses", int'(dvec), int'(e.vec));
      chk("evt_cnt_at_event", int'(evt_cnt), int'(e.cnt));
    end else begin
      chk("no_pulse", int'(dvec), 0);
    end
    chk("held", int'(held), int'(m_held));
  end

  // ---------------- stimulus ----------------
  task automatic hold(input logic lvl, input int n);
    btn_z = lvl;
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  initial begin
    reset_z = 1'b0;
    btn_z   = 1'b1;
    enable  = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    chk("reset_held", int'(held), 0);
    chk("reset_pulses", int'({press_p, release_p, short_p, double_p, long_p}), 0);
    chk("reset_evt_cnt", int'(evt_cnt), 0);
    reset_z = 1'b1;
    hold(1'b1, 5);

    // single click: short_p 20 cycles after release_p
    hold(1'b0, 20); hold(1'b1, 30);
    chk("evt_cnt_single", int'(evt_cnt), 1);
    // long hold: long_p 40 cycles after press_p, release gives release_p only
    hold(1'b0, 60); hold(1'b1, 30);
    chk("evt_cnt_long", int'(evt_cnt), 2);
    // double click
    hold(1'b0, 8); hold(1'b1, 8); hold(1'b0, 8); hold(1'b1, 30);
    chk("evt_cnt_double", int'(evt_cnt), 3);
    // release exactly on long expiry
    hold(1'b0, 40); hold(1'b1, 30);
    // second press exactly on gap expiry
    hold(1'b0, 8); hold(1'b1, 20); hold(1'b0, 8); hold(1'b1, 30);
    chk("evt_cnt_collisions", int'(evt_cnt), 5);
    // disabled press, re-enabled while held: nothing; fresh press is normal
    enable = 1'b0; hold(1'b0, 10);
    enable = 1'b1; hold(1'b0, 10); hold(1'b1, 30);
    chk("evt_cnt_enable_quiet", int'(evt_cnt), 5);
    hold(1'b0, 10); hold(1'b1, 30);
    chk("evt_cnt_after_enable", int'(evt_cnt), 6);
    // reset in the middle of the double-click gap
    hold(1'b0, 8); hold(1'b1, 5);
    reset_z = 1'b0; hold(1'b1, 3);
    reset_z = 1'b1; hold(1'b1, 40);
    chk("evt_cnt_after_reset", int'(evt_cnt), 0);

    // randomized gestures, biased toward the timing boundaries
    for (int i = 0; i < 160; i++) begin
      int r, d;
      logic lvl;
      lvl = i[0];
      r = int'($urandom_range(0, 99));
      if (r < 6) enable = ~enable;
      if (r == 99) begin
        reset_z = 1'b0; hold(btn_z, 2); reset_z = 1'b1;
      end
      if ($urandom_range(0, 1) == 1) d = int'($urandom_range(1, 60));
      else if (lvl) d = DM * TD - 1 + int'($urandom_range(0, 2));
      else d = LM * TD - 1 + int'($urandom_range(0, 2));
      hold(lvl, d);
    end
    enable = 1'b1;
    hold(1'b1, 60);
    chk("evt_cnt_final", int'(evt_cnt), int'(m_cnt));
    chk("queue_drained", q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
